load_wb_queue: RTL
==================

Name: load_wb_queue

Overview:
- Parametrised writeback-stage load tracker for the MIPS pipeline.
- Queues descriptors of outstanding data-bus loads, pops them in order as responses return, and aligns and extends the returned word.
- Registers the result one cycle, then drives the single register-file write port, arbitrating against the ALU writeback.
- Sits between the memory stage, the dbus response and the regfile; also supplies a forwarding view of the registered result.

Parameters:
- DEPTH, 4, max outstanding loads; power of two, 2..16.
- REG_W, 5, register index width.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- issue_valid  in  1  memory stage presents a load.
- issue_ready  out  1  queue can accept the load.
- issue_dst  in  REG_W  destination register.
- issue_op  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 LWL, 110 LWR, 111 treated as LW.
- issue_off  in  2  byte address [1:0].
- issue_old  in  32  current rt value (used only for LWL/LWR).
- issue_exc  in  1  load raised an exception; not enqueued, no bus request outstanding.
- resp_valid  in  1  dbus data beat for the queue head.
- resp_data  in  32  raw word.
- flush  in  1  kill all queued entries.
- alu_valid  in  1  ALU result wants the write port.
- alu_dst  in  REG_W  ALU destination register.
- alu_data  in  32  ALU result.
- alu_ready  out  1  ALU write accepted this cycle.
- wr_en  out  1  regfile write enable.
- wr_reg  out  REG_W  regfile write index.
- wr_data  out  32  regfile write data.
- fwd_valid  out  1  registered load result valid.
- fwd_reg  out  REG_W  register of that result.
- fwd_data  out  32  data of that result.
- pending  out  CNT_W  live queue occupancy.
- resp_err  out  1  sticky flag: response arrived with the queue empty.

Behaviour:
- Reset (async, resetn=0): queue empty, head/tail=0, pending=0, all kill bits 0, result register invalid, resp_err=0, wr_en=0, wr_reg=0, wr_data=0, fwd_valid=0.
- Enqueue: issue_valid & issue_ready & !issue_exc writes {dst, op, off, old, kill=0} at tail; tail wraps mod DEPTH.
- issue_ready = (pending != DEPTH). A pop in the same cycle does not free a slot for that cycle's issue.
- Pop: resp_valid & pending!=0 removes the head entry; head wraps mod DEPTH.
  - Extracted data lands in the result register next edge (1-cycle latency): valid=!kill, reg=dst, data=aligned word.
  - Simultaneous push and pop leaves pending unchanged.
- resp_valid with pending==0: data dropped, resp_err set; resp_err clears only on reset.
- Alignment:
  - LB/LBU select byte off; LH/LHU select half off[1], off[0] ignored.
  - Sign-extend for LB/LH, zero-extend for LBU/LHU.
  - LW passes the word through.
- flush: sets kill on every entry present at that edge, including one enqueued the same cycle.
  - Killed entries still pop on their response and produce no write.
  - pending is unaffected by flush.
- Write port:
  - A valid result register has priority: wr_en=1, wr_reg/wr_data from the result register, alu_ready=0.
  - Otherwise alu_ready=1; if alu_valid, writes alu_dst/alu_data.
  - Result register clears after its write cycle.
- Register 0: wr_en forced 0 when wr_reg==0. The winning source is still considered consumed.
- fwd_*: mirrors the result register; fwd_valid=0 when reg==0.

Optional Feature:
- UNALIGNED_LOAD_EN defined: LWL/LWR merge resp_data with the stored issue_old, big-endian-free MIPS little-endian rules.
  - LWL off=n: bytes [3:3-n] of result = resp_data bytes [n:0]; rest from old.
  - LWR off=n: bytes [3-n:0] of result = resp_data bytes [3:n]; rest from old.
- Undefined: 101/110 behave as LW; the issue_old storage is not instantiated.

Test Plan:
- Reset mid-flight: 3 loads queued, resetn=0 → pending=0, wr_en=0, issue_ready=1 immediately (asynchronous).
- LB dst=4 off=3, resp 0x80FF_0000 → one cycle later wr_en=1, wr_reg=4, wr_data=0xFFFF_FF80. The same load as LBU gives 0x0000_0080.
- Fill DEPTH=4 loads, 5th issue → issue_ready=0. Responses pop the entries in order; a wrap past the index-3 slot gives correct dst order.
- flush with 2 entries, then 2 responses → no writes; pending 2→0; an entry issued after the flush writes normally.
- Result pending while alu_valid dst=7 → alu_ready=0 for that cycle; ALU write lands the next cycle. Load to r0 → wr_en=0.
- resp_valid with an empty queue → resp_err=1 and stays set. With UNALIGNED_LOAD_EN, LWL off=1, old=0x1122_3344, resp=0xAABB_CCDD → 0xCCDD_3344.

Source files
------------

// File: rtl/load_wb_queue.sv
// ============================================================================
// load_wb_queue
// ----------------------------------------------------------------------------
// Writeback-stage load tracker for the MIPS pipeline.
//
// Outstanding data-bus loads are recorded in an in-order circular queue when
// the memory stage issues them. Each dbus response pops the queue head. The
// returned word is aligned and extended, then captured in a one-entry result
// register. That register owns the single regfile write port ahead of the ALU.
//
// Build option:
//   UNALIGNED_LOAD_EN - when defined, LWL/LWR merge the response with the rt
//                       value captured at issue. When undefined, those
//                       opcodes act as LW and no rt storage is built.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   issue_*            load descriptor from the memory stage (valid/ready)
//   resp_valid/data    dbus data beat for the queue head
//   flush              kill every queued load (they still drain on response)
//   alu_valid/dst/data ALU writeback request; alu_ready = accepted this cycle
//   wr_en/reg/data     regfile write port
//   fwd_valid/reg/data forwarding view of the result register
//   pending            live queue occupancy
//   resp_err           sticky: a response arrived with nothing outstanding
// ============================================================================
module load_wb_queue #(
    parameter int DEPTH = 4,
    parameter int REG_W = 5,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [REG_W-1:0] issue_dst,
    input  logic [2:0]       issue_op,
    input  logic [1:0]       issue_off,
    input  logic [31:0]      issue_old,
    input  logic             issue_exc,
    input  logic             resp_valid,
    input  logic [31:0]      resp_data,
    input  logic             flush,
    input  logic             alu_valid,
    input  logic [REG_W-1:0] alu_dst,
    input  logic [31:0]      alu_data,
    output logic             alu_ready,
    output logic             wr_en,
    output logic [REG_W-1:0] wr_reg,
    output logic [31:0]      wr_data,
    output logic             fwd_valid,
    output logic [REG_W-1:0] fwd_reg,
    output logic [31:0]      fwd_data,
    output logic [CNT_W-1:0] pending,
    output logic             resp_err
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LH  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
`ifdef UNALIGNED_LOAD_EN
    localparam logic [2:0] OP_LWL = 3'b101;
    localparam logic [2:0] OP_LWR = 3'b110;
`endif

    // ------------------------------------------------------------------
    // Alignment helpers
    // ------------------------------------------------------------------
    // Sub-word select and extend. LW, 111 and (in the default build)
    // LWL/LWR fall through to the raw word.
    function automatic logic [31:0] f_align(input logic [2:0]  op,
                                            input logic [1:0]  off,
                                            input logic [31:0] data);
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        logic [31:0] v_res;
        case (off)
            2'd0:    v_byte = data[7:0];
            2'd1:    v_byte = data[15:8];
            2'd2:    v_byte = data[23:16];
            2'd3:    v_byte = data[31:24];
            default: v_byte = data[7:0];
        endcase
        v_half = off[1] ? data[31:16] : data[15:0];
        case (op)
            OP_LB:   v_res = {{24{v_byte[7]}}, v_byte};
            OP_LBU:  v_res = {24'h00_0000, v_byte};
            OP_LH:   v_res = {{16{v_half[15]}}, v_half};
            OP_LHU:  v_res = {16'h0000, v_half};
            default: v_res = data;
        endcase
        return v_res;
    endfunction

`ifdef UNALIGNED_LOAD_EN
    // LWL: low (off+1) response bytes fill the top of the register.
    function automatic logic [31:0] f_lwl(input logic [1:0]  off,
                                          input logic [31:0] data,
                                          input logic [31:0] old);
        logic [31:0] v_res;
        case (off)
            2'd0:    v_res = {data[7:0],  old[23:0]};
            2'd1:    v_res = {data[15:0], old[15:0]};
            2'd2:    v_res = {data[23:0], old[7:0]};
            2'd3:    v_res = data;
            default: v_res = data;
        endcase
        return v_res;
    endfunction

    // LWR: response bytes from off upward fill the bottom of the register.
    function automatic logic [31:0] f_lwr(input logic [1:0]  off,
                                          input logic [31:0] data,
                                          input logic [31:0] old);
        logic [31:0] v_res;
        case (off)
            2'd0:    v_res = data;
            2'd1:    v_res = {old[31:24], data[31:8]};
            2'd2:    v_res = {old[31:16], data[31:16]};
            2'd3:    v_res = {old[31:8],  data[31:24]};
            default: v_res = data;
        endcase
        return v_res;
    endfunction
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [REG_W-1:0] r_q_dst [DEPTH];
    logic [2:0]       r_q_op  [DEPTH];
    logic [1:0]       r_q_off [DEPTH];
    logic [DEPTH-1:0] r_q_kill;
`ifdef UNALIGNED_LOAD_EN
    logic [31:0]      r_q_old [DEPTH];
`else
    logic             w_unused_old;
`endif
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_res_valid;
    logic [REG_W-1:0] r_res_reg;
    logic [31:0]      r_res_data;
    logic             r_resp_err;

    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_kill_next;
    logic [31:0]      w_res_data;
    logic             w_wr_sel;

`ifndef UNALIGNED_LOAD_EN
    assign w_unused_old = ^issue_old;
`endif

    // Readiness looks only at registered occupancy, so a same-cycle pop
    // never opens a slot for the issue presented in that cycle.
    assign issue_ready = (r_count != FULL_CNT);
    assign w_push      = issue_valid & issue_ready & ~issue_exc;
    assign w_pop       = resp_valid & (r_count != '0);

    // Kill-bit update: flush marks every slot (stale slots are cleared again
    // on enqueue), so a load enqueued in the flush cycle is killed as well.
    always_comb begin
        w_kill_next = r_q_kill;
        if (flush) begin
            w_kill_next = '1;
        end else if (w_push) begin
            w_kill_next[r_tail] = 1'b0;
        end else begin
            w_kill_next = r_q_kill;
        end
    end

    // Align/extend the response according to the head descriptor.
    always_comb begin
`ifdef UNALIGNED_LOAD_EN
        case (r_q_op[r_head])
            OP_LWL:  w_res_data = f_lwl(r_q_off[r_head], resp_data, r_q_old[r_head]);
            OP_LWR:  w_res_data = f_lwr(r_q_off[r_head], resp_data, r_q_old[r_head]);
            default: w_res_data = f_align(r_q_op[r_head], r_q_off[r_head], resp_data);
        endcase
`else
        w_res_data = f_align(r_q_op[r_head], r_q_off[r_head], resp_data);
`endif
    end

    // Descriptor storage written at the tail; kill bits tracked per slot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_dst[i] <= '0;
                r_q_op[i]  <= 3'b000;
                r_q_off[i] <= 2'b00;
`ifdef UNALIGNED_LOAD_EN
                r_q_old[i] <= 32'h0000_0000;
`endif
            end
            r_q_kill <= '0;
        end else begin
            if (w_push) begin
                r_q_dst[r_tail] <= issue_dst;
                r_q_op[r_tail]  <= issue_op;
                r_q_off[r_tail] <= issue_off;
`ifdef UNALIGNED_LOAD_EN
                r_q_old[r_tail] <= issue_old;
`endif
            end
            r_q_kill <= w_kill_next;
        end
    end

    // Head/tail pointers (natural wrap, DEPTH is a power of two) and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Result register: loaded on every pop, otherwise emptied because a
    // valid result always wins the write port in the cycle it is held.
    // A flush coinciding with the pop kills the popping entry too.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_res_valid <= 1'b0;
            r_res_reg   <= '0;
            r_res_data  <= 32'h0000_0000;
        end else if (w_pop) begin
            r_res_valid <= ~r_q_kill[r_head] & ~flush;
            r_res_reg   <= r_q_dst[r_head];
            r_res_data  <= w_res_data;
        end else begin
            r_res_valid <= 1'b0;
        end
    end

    // Sticky error for a response with no outstanding load.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_resp_err <= 1'b0;
        end else if (resp_valid && (r_count == '0)) begin
            r_resp_err <= 1'b1;
        end else begin
            r_resp_err <= r_resp_err;
        end
    end

    // Write-port arbitration: load result first, ALU otherwise.
    always_comb begin
        w_wr_sel  = 1'b0;
        wr_reg    = '0;
        wr_data   = 32'h0000_0000;
        alu_ready = 1'b0;
        if (r_res_valid) begin
            w_wr_sel = 1'b1;
            wr_reg   = r_res_reg;
            wr_data  = r_res_data;
        end else begin
            alu_ready = 1'b1;
            if (alu_valid) begin
                w_wr_sel = 1'b1;
                wr_reg   = alu_dst;
                wr_data  = alu_data;
            end else begin
                w_wr_sel = 1'b0;
            end
        end
    end

    // r0 is hardwired: the winner is consumed but no write is issued.
    assign wr_en     = w_wr_sel & (wr_reg != '0);

    assign fwd_valid = r_res_valid & (r_res_reg != '0);
    assign fwd_reg   = r_res_reg;
    assign fwd_data  = r_res_data;
    assign pending   = r_count;
    assign resp_err  = r_resp_err;

endmodule
